// File: rtl/csr_timer_intc_pkg.sv
// rtl/csr_timer_intc_pkg.sv - CSR timer/interrupt constants, TCFG layout and channel address helper
package csr_timer_intc_pkg;

  localparam logic [13:0] TMR0_BASE = 14'h041;
  localparam logic [13:0] TMRX_BASE = 14'h1C0;

  localparam logic [13:0] TCFG_OFS  = 14'd0;
  localparam logic [13:0] TVAL_OFS  = 14'd1;
  localparam logic [13:0] TICLR_OFS = 14'd3;

  localparam int TCFG_EN_BIT       = 0;
  localparam int TCFG_PERIODIC_BIT = 1;
  localparam int TCFG_INITVAL_LSB  = 2;

  typedef struct packed {
    logic [31:TCFG_INITVAL_LSB] initval;
    logic                       periodic;
    logic                       en;
  } tmr_cfg_t;

  // Channel 0 keeps its legacy slot; extra channels sit on a 4-address stride.
  function automatic logic [13:0] tmr_base(input int k);
    return (k == 0) ? TMR0_BASE : TMRX_BASE + 14'(4 * k);
  endfunction

endpackage

// File: rtl/csr_timer_chan.sv
// rtl/csr_timer_chan.sv - one TCFG/TVAL/TICLR timer channel with its pending bit
module csr_timer_chan
  import csr_timer_intc_pkg::*;
#(
  parameter int TIMESIZE = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_we_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] wmask_i,
  input  logic        clr_i,
  output logic        pend_o,
  output logic [31:0] tcfg_o,
  output logic [31:0] tval_o
);

  localparam logic [31:0] CFG_MASK = 32'((64'd1 << TIMESIZE) - 64'd1);

  tmr_cfg_t            cfg_q, cfg_d, cfg_new;
  logic [TIMESIZE-1:0] tval_q, tval_d;
  logic                armed_q, armed_d;
  logic                pend_q, pend_d;
  logic                fire;

  assign cfg_new = tmr_cfg_t'(((cfg_q & ~wmask_i) | (wdata_i & wmask_i)) & CFG_MASK);
  assign fire    = armed_q && (tval_q == '0);

  // A fire always sets pend, so it beats a same-edge clear and survives a TCFG rewrite.
  always_comb begin
    cfg_d   = cfg_q;
    tval_d  = tval_q;
    armed_d = armed_q;
    if (cfg_we_i) begin
      cfg_d   = cfg_new;
      tval_d  = TIMESIZE'({cfg_new.initval, 2'b00});
      armed_d = cfg_new[TCFG_EN_BIT];
    end else if (armed_q) begin
      if (tval_q != '0) begin
        tval_d = tval_q - TIMESIZE'(1);
      end else if (cfg_q[TCFG_PERIODIC_BIT]) begin
        tval_d = TIMESIZE'({cfg_q.initval, 2'b00});
      end else begin
        armed_d = 1'b0;
      end
    end
    pend_d = fire | (pend_q & ~clr_i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_q   <= '0;
      tval_q  <= '0;
      armed_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      cfg_q   <= cfg_d;
      tval_q  <= tval_d;
      armed_q <= armed_d;
      pend_q  <= pend_d;
    end
  end

  assign pend_o = pend_q;
  assign tcfg_o = cfg_q;
  assign tval_o = 32'(tval_q);

endmodule

// File: rtl/csr_timer_intc.sv
// rtl/csr_timer_intc.sv - timer channels, stable counter, interrupt synchronisers and request
module csr_timer_intc
  import csr_timer_intc_pkg::*;
#(
  parameter int TIMESIZE   = 32,
  parameter int NUM_TIMERS = 1,
  parameter int COUNTER_W  = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 csr_we,
  input  logic [13:0]          csr_waddr,
  input  logic [31:0]          csr_wdata,
  input  logic [31:0]          csr_wmask,
  input  logic [13:0]          csr_raddr,
  output logic [31:0]          csr_rdata,
  input  logic [7:0]           hwi,
  input  logic                 ipi,
  input  logic [12:0]          ecfg_lie,
  input  logic [1:0]           estat_sw,
  input  logic                 crmd_ie,
  output logic [10:0]          estat_is_hw,
  output logic                 int_req,
  output logic [COUNTER_W-1:0] stable_cnt
);

  logic [NUM_TIMERS-1:0] pend;
  logic [31:0]           tcfg_rd [NUM_TIMERS];
  logic [31:0]           tval_rd [NUM_TIMERS];

  for (genvar k = 0; k < NUM_TIMERS; k++) begin : g_chan
    localparam logic [13:0] BASE = tmr_base(k);
    csr_timer_chan #(
      .TIMESIZE (TIMESIZE)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .cfg_we_i (csr_we && (csr_waddr == BASE + TCFG_OFS)),
      .wdata_i  (csr_wdata),
      .wmask_i  (csr_wmask),
      .clr_i    (csr_we && (csr_waddr == BASE + TICLR_OFS) && csr_wdata[0] && csr_wmask[0]),
      .pend_o   (pend[k]),
      .tcfg_o   (tcfg_rd[k]),
      .tval_o   (tval_rd[k])
    );
  end

  // TICLR and unmapped addresses fall through to zero.
  always_comb begin
    csr_rdata = '0;
    for (int k = 0; k < NUM_TIMERS; k++) begin
      if (csr_raddr == tmr_base(k) + TCFG_OFS) csr_rdata = tcfg_rd[k];
      if (csr_raddr == tmr_base(k) + TVAL_OFS) csr_rdata = tval_rd[k];
    end
  end

  logic [7:0]           hwi_s1_q, hwi_s2_q;
  logic                 ipi_q;
  logic                 int_req_q, int_req_d;
  logic [COUNTER_W-1:0] cnt_q, cnt_d;

  assign estat_is_hw = {ipi_q, |pend, 1'b0, hwi_s2_q};
  assign int_req_d   = crmd_ie & |(ecfg_lie & {estat_is_hw, estat_sw});
  assign cnt_d       = cnt_q + COUNTER_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      hwi_s1_q  <= '0;
      hwi_s2_q  <= '0;
      ipi_q     <= 1'b0;
      int_req_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      hwi_s1_q  <= hwi;
      hwi_s2_q  <= hwi_s1_q;
      ipi_q     <= ipi;
      int_req_q <= int_req_d;
      cnt_q     <= cnt_d;
    end
  end

  assign int_req    = int_req_q;
  assign stable_cnt = cnt_q;

endmodule

// File: tb/tb_csr_timer_intc.sv
// tb/tb_csr_timer_intc.sv - scoreboard bench for csr_timer_intc with two channels and an 8-bit counter
module tb_csr_timer_intc;

  localparam int SEL_RD  = 0;
  localparam int SEL_IS  = 1;
  localparam int SEL_IRQ = 2;
  localparam int SEL_CNT = 3;

  logic        clk;
  logic        reset;
  logic        csr_we;
  logic [13:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_wmask;
  logic [13:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic [7:0]  hwi;
  logic        ipi;
  logic [12:0] ecfg_lie;
  logic [1:0]  estat_sw;
  logic        crmd_ie;
  logic [10:0] estat_is_hw;
  logic        int_req;
  logic [7:0]  stable_cnt;

  csr_timer_intc #(
    .TIMESIZE   (32),
    .NUM_TIMERS (2),
    .COUNTER_W  (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .csr_we      (csr_we),
    .csr_waddr   (csr_waddr),
    .csr_wdata   (csr_wdata),
    .csr_wmask   (csr_wmask),
    .csr_raddr   (csr_raddr),
    .csr_rdata   (csr_rdata),
    .hwi         (hwi),
    .ipi         (ipi),
    .ecfg_lie    (ecfg_lie),
    .estat_sw    (estat_sw),
    .crmd_ie     (crmd_ie),
    .estat_is_hw (estat_is_hw),
    .int_req     (int_req),
    .stable_cnt  (stable_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  chk_t        sb_q[$];
  chk_t        mon_c;
  logic [31:0] mon_act;
  int          passed = 0;
  int          total  = 0;

  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      mon_c = sb_q.pop_front();
      case (mon_c.sel)
        SEL_RD:  mon_act = csr_rdata;
        SEL_IS:  mon_act = 32'(estat_is_hw);
        SEL_IRQ: mon_act = 32'(int_req);
        default: mon_act = 32'(stable_cnt);
      endcase
      total++;
      if (mon_act === mon_c.exp) passed++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", mon_c.name, mon_act, mon_c.exp);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_out(input string nm, input int sel, input logic [31:0] v);
    chk_t c;
    c.name = nm;
    c.sel  = sel;
    c.exp  = v;
    sb_q.push_back(c);
  endtask

  task automatic exp_rd(input string nm, input logic [13:0] a, input logic [31:0] v);
    csr_raddr = a;
    exp_out(nm, SEL_RD, v);
  endtask

  task automatic csr_write(input logic [13:0] a, input logic [31:0] d, input logic [31:0] m);
    csr_we    = 1'b1;
    csr_waddr = a;
    csr_wdata = d;
    csr_wmask = m;
    tick();
    csr_we    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; csr_we = 1'b0; csr_waddr = '0; csr_wdata = '0; csr_wmask = '0;
    csr_raddr = '0; hwi = '0; ipi = 1'b0; ecfg_lie = '0; estat_sw = '0; crmd_ie = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    // reset state
    exp_rd("rst_tcfg0", 14'h041, 32'h0);
    exp_out("rst_is", SEL_IS, 32'h0);
    exp_out("rst_irq", SEL_IRQ, 32'h0);
    exp_out("rst_cnt", SEL_CNT, 32'h0);

    // stable counter wrap
    repeat (255) tick();
    exp_out("cnt_255", SEL_CNT, 32'd255);
    tick();
    exp_out("cnt_wrap", SEL_CNT, 32'd0);

    // one-shot, InitVal=2
    csr_write(14'h041, 32'h9, 32'hFFFF_FFFF);
    for (int i = 0; i <= 8; i++) begin
      exp_rd($sformatf("os_tval_%0d", i), 14'h042, 32'(8 - i));
      exp_out($sformatf("os_nopend_%0d", i), SEL_IS, 32'h0);
      tick();
    end
    exp_out("os_pend", SEL_IS, 32'h200);
    exp_rd("os_tval_zero", 14'h042, 32'h0);
    repeat (6) tick();
    exp_out("os_pend_held", SEL_IS, 32'h200);
    exp_rd("os_tval_held", 14'h042, 32'h0);
    tick();
    exp_rd("ticlr_reads0", 14'h044, 32'h0);
    csr_write(14'h044, 32'h1, 32'h1);
    exp_out("os_clr", SEL_IS, 32'h0);
    repeat (8) tick();
    exp_out("os_no_refire", SEL_IS, 32'h0);
    exp_rd("os_tcfg", 14'h041, 32'h9);

    // periodic, InitVal=1: fires every 5 cycles
    csr_write(14'h041, 32'h7, 32'hFFFF_FFFF);
    exp_rd("per_tval_4", 14'h042, 32'h4);
    for (int i = 1; i <= 4; i++) begin
      tick();
      exp_out($sformatf("per_nopend_%0d", i), SEL_IS, 32'h0);
      exp_rd($sformatf("per_tval_%0d", 4 - i), 14'h042, 32'(4 - i));
    end
    tick();
    exp_out("per_fire1", SEL_IS, 32'h200);
    exp_rd("per_reload", 14'h042, 32'h4);
    csr_write(14'h044, 32'h1, 32'h1);
    exp_out("per_clr", SEL_IS, 32'h0);
    exp_rd("per_tval_3b", 14'h042, 32'h3);
    repeat (3) tick();
    exp_out("per_pre_fire2", SEL_IS, 32'h0);
    exp_rd("per_tval_0b", 14'h042, 32'h0);
    csr_write(14'h044, 32'h1, 32'h1);
    exp_out("per_clr_vs_fire", SEL_IS, 32'h200);
    exp_rd("per_reload2", 14'h042, 32'h4);
    repeat (5) tick();
    exp_out("per_fire3", SEL_IS, 32'h200);
    csr_write(14'h041, 32'h0, 32'hFFFF_FFFF);
    csr_write(14'h044, 32'h1, 32'h1);
    exp_out("per_off_clr", SEL_IS, 32'h0);
    exp_rd("per_off_tval", 14'h042, 32'h0);

    // masked write: only En is cleared
    csr_write(14'h041, 32'h103, 32'hFFFF_FFFF);
    csr_write(14'h041, 32'h0, 32'h1);
    exp_rd("mask_tcfg", 14'h041, 32'h102);
    tick();
    exp_rd("mask_tval", 14'h042, 32'h100);
    repeat (3) tick();
    exp_rd("mask_tval_held", 14'h042, 32'h100);
    exp_out("mask_nopend", SEL_IS, 32'h0);
    tick();
    exp_rd("unmapped_043", 14'h043, 32'h0);
    tick();
    exp_rd("unmapped_1c8", 14'h1C8, 32'h0);
    tick();
    exp_rd("unmapped_000", 14'h000, 32'h0);

    // channel 1 one-shot, InitVal=1, timer line enabled
    ecfg_lie = 13'h800;
    crmd_ie  = 1'b1;
    csr_write(14'h1C4, 32'h5, 32'hFFFF_FFFF);
    exp_rd("ch1_tval_4", 14'h1C5, 32'h4);
    exp_out("ch1_nopend_0", SEL_IS, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      exp_rd($sformatf("ch1_tval_%0d", 4 - i), 14'h1C5, 32'(4 - i));
      exp_out($sformatf("ch1_nopend_%0d", i), SEL_IS, 32'h0);
      exp_out($sformatf("ch1_noirq_%0d", i), SEL_IRQ, 32'h0);
    end
    tick();
    exp_out("ch1_pend", SEL_IS, 32'h200);
    exp_out("ch1_irq_lag", SEL_IRQ, 32'h0);
    exp_rd("ch0_tval_kept", 14'h042, 32'h100);
    tick();
    exp_out("ch1_irq", SEL_IRQ, 32'h1);
    exp_rd("ch0_tcfg_kept", 14'h041, 32'h102);
    csr_write(14'h1C7, 32'h1, 32'h1);
    exp_out("ch1_clr", SEL_IS, 32'h0);
    exp_out("ch1_irq_tail", SEL_IRQ, 32'h1);
    exp_rd("ch1_tcfg", 14'h1C4, 32'h5);
    tick();
    exp_out("ch1_irq_off", SEL_IRQ, 32'h0);
    exp_rd("ch1_tval_held", 14'h1C5, 32'h0);

    // hwi[3] held 3 cycles, IS[5] enabled
    ecfg_lie = 13'h020;
    hwi      = 8'h08;
    tick();
    exp_out("hwi_e1_is", SEL_IS, 32'h0);
    exp_out("hwi_e1_irq", SEL_IRQ, 32'h0);
    tick();
    exp_out("hwi_e2_is", SEL_IS, 32'h008);
    exp_out("hwi_e2_irq", SEL_IRQ, 32'h0);
    tick();
    exp_out("hwi_e3_irq", SEL_IRQ, 32'h1);
    hwi     = 8'h00;
    crmd_ie = 1'b0;
    tick();
    exp_out("hwi_ie0_irq", SEL_IRQ, 32'h0);
    exp_out("hwi_e4_is", SEL_IS, 32'h008);
    tick();
    exp_out("hwi_e5_is", SEL_IS, 32'h0);

    // ipi
    ecfg_lie = 13'h1000;
    crmd_ie  = 1'b1;
    ipi      = 1'b1;
    tick();
    exp_out("ipi_is", SEL_IS, 32'h400);
    exp_out("ipi_irq_lag", SEL_IRQ, 32'h0);
    tick();
    exp_out("ipi_irq", SEL_IRQ, 32'h1);
    ipi      = 1'b0;
    crmd_ie  = 1'b0;
    ecfg_lie = 13'h0;
    tick();
    exp_out("ipi_off_is", SEL_IS, 32'h0);
    exp_out("ipi_off_irq", SEL_IRQ, 32'h0);

    // reset mid-count with everything active
    hwi      = 8'hFF;
    ipi      = 1'b1;
    ecfg_lie = 13'h1FFF;
    crmd_ie  = 1'b1;
    csr_write(14'h041, 32'hB, 32'hFFFF_FFFF);
    repeat (2) tick();
    exp_out("pre_rst_is", SEL_IS, 32'h4FF);
    exp_out("pre_rst_irq", SEL_IRQ, 32'h1);
    exp_rd("pre_rst_tval", 14'h042, 32'h6);
    reset = 1'b1;
    tick();
    exp_out("mid_rst_is", SEL_IS, 32'h0);
    exp_out("mid_rst_irq", SEL_IRQ, 32'h0);
    exp_out("mid_rst_cnt", SEL_CNT, 32'h0);
    exp_rd("mid_rst_tval", 14'h042, 32'h0);
    reset = 1'b0;
    hwi   = 8'h00;
    ipi   = 1'b0;
    tick();
    exp_rd("post_rst_tcfg", 14'h041, 32'h0);
    repeat (4) tick();
    exp_out("post_rst_cnt", SEL_CNT, 32'd5);
    exp_out("post_rst_is", SEL_IS, 32'h0);
    exp_out("post_rst_irq", SEL_IRQ, 32'h0);
    exp_rd("post_rst_tval", 14'h042, 32'h0);
    estat_sw = 2'b01;
    tick();
    exp_out("sw_irq", SEL_IRQ, 32'h1);

    @(negedge clk);
    #1;
    total++;
    if (sb_q.size() == 0) passed++;
    else $display("FAIL sb_drain: got %0d pending, want 0", sb_q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
